byte_unstriping: RTL and testbench
==================================

Name: byte_unstriping

Overview:
Receive-side counterpart of byte_striping. Accepts one lane group per handshake: one byte per lane, plus a per-lane K flag. Re-serializes the group into a single byte stream at one byte per CLK, lane 0 first. Tracks packet framing (STP/SDP … END/EDB) and flags framing violations.

Parameters:
LANES, 4, number of lanes; legal values 2 or 4; LANE2/LANE3 are ignored when LANES=2
BITS, 8, byte width; the K-code compare uses the low 8 bits

Ports:
CLK  input  1  clock, all logic on posedge
RESET  input  1  synchronous, active-high reset
LANE0  input  BITS  byte for lane 0 (earliest byte of the group)
LANE1  input  BITS  byte for lane 1
LANE2  input  BITS  byte for lane 2
LANE3  input  BITS  byte for lane 3
LANE_K  input  LANES  bit i=1 marks LANEi as a K (control) symbol
IN_VALID  input  1  group present on the LANE* inputs
IN_READY  output  1  block can accept a group this cycle
D  output  BITS  serialized byte
DK  output  1  K flag of D
D_VALID  output  1  D/DK are meaningful this cycle
IN_PKT  output  1  framing FSM is in state PKT
FRAME_ERR  output  1  one-cycle pulse aligned with the offending byte

Behaviour:
- Reset (RESET=1 at posedge):
  - D, DK, D_VALID, IN_PKT, FRAME_ERR=0; IN_READY=0 while RESET is high.
  - Group buffer emptied; lane index=0; FSM=IDLE.
  - Reset mid-group discards the remaining bytes, with no error.
- Group buffer: 2 entries (width LANES*(BITS+1)).
  - IN_READY = (count<2), taken from registered state only; no same-cycle bypass when full.
  - Push when IN_VALID & IN_READY.
  - Push and pop in the same cycle: count unchanged.
- Serializer: lane index 0..LANES-1 over the head entry.
  - Each cycle the buffer is non-empty: register D=lane[idx] and DK=K[idx], set D_VALID=1, then idx++.
  - On idx=LANES-1: pop the entry and wrap idx to 0.
  - Buffer empty: D_VALID=0; D/DK hold their last values.
- Latency: group pushed at edge t into an empty buffer → lane0 byte valid after edge t+1.
  - Back-to-back groups stream with no bubble.
  - Sustained throughput: 1 group per LANES cycles.
- K codes: STP=FB, SDP=5C, END=FD, EDB=FE, COM=BC, SKP=1C, IDL=7C.
- Framing FSM {IDLE, PKT}, evaluated on each emitted byte; FRAME_ERR is registered together with that byte:
  - IDLE + K STP/SDP → PKT.
  - IDLE + K COM/SKP/IDL → stay IDLE.
  - IDLE + data byte → FRAME_ERR, stay IDLE.
  - IDLE + K END/EDB → FRAME_ERR, stay IDLE.
  - PKT + data byte → stay PKT.
  - PKT + K END/EDB → IDLE.
  - PKT + K STP/SDP → FRAME_ERR, stay PKT (new packet).
  - PKT + K IDL → FRAME_ERR, go IDLE.
  - PKT + K COM/SKP → stay PKT.
  - Any unknown K code → FRAME_ERR, state unchanged.
- Bytes are always forwarded, even when they raise FRAME_ERR.
- IN_PKT is registered; it reflects the state after the byte currently on D.

Optional Feature:
- Macro: BYTE_UNSTRIPING_SKP_DROP_EN.
- Defined: a K SKP byte still consumes its serializer slot but is emitted with D_VALID=0. FSM and FRAME_ERR ignore it.
- Undefined: SKP is forwarded like any other K symbol.

Decomposition:
- Shared package byte_strip_pkg holds:
  - K-code localparams STP/SDP/END/EDB/COM/SKP/IDL.
  - Framing state encoding IDLE=0, PKT=1.
  - Lane-count legality constant.
- Sub-module lane_group_fifo: 2-entry synchronous FIFO with count-based full/empty. Serializer and FSM remain in byte_unstriping.

Test Plan:
- Reset then one group {K FB, 33, FF, K FD} with LANE_K=1001 → D sequence FB,33,FF,FD on consecutive cycles, DK=1,0,0,1, IN_PKT 1,1,1,0, FRAME_ERR never set.
- Three groups offered with IN_VALID held high → IN_READY drops after 2 pushes, rises once the first pop completes; 12 contiguous D_VALID cycles, byte order preserved.
- Group {AA, BB, CC, DD}, no K, issued in IDLE → four FRAME_ERR pulses, each aligned with the matching byte; IN_PKT stays 0.
- Group {K FB, 11, K FB, 22} → FRAME_ERR only on the third byte; IN_PKT=1 throughout.
- RESET asserted after 2 of 4 bytes have been emitted → D_VALID=0 the next cycle, IN_READY=0 during reset, no further bytes from the old group.
- With BYTE_UNSTRIPING_SKP_DROP_EN: group {K BC, K 1C, K 1C, K 1C} → only BC emitted with D_VALID=1; the next 3 cycles have D_VALID=0. Without the macro: all 4 emitted.

Source files
------------

// File: rtl/byte_strip_pkg.sv
// Shared constants for the byte striping/unstriping pair: K-code values,
// framing state encoding and the lane-count legality check.
package byte_strip_pkg;

    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_SDP = 8'h5C;
    localparam logic [7:0] K_END = 8'hFD;
    localparam logic [7:0] K_EDB = 8'hFE;
    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_SKP = 8'h1C;
    localparam logic [7:0] K_IDL = 8'h7C;

    typedef enum logic {
        FRAME_IDLE = 1'b0,
        FRAME_PKT  = 1'b1
    } frame_state_e;

    // Widest supported lane group; only 2 and 4 lanes are legal.
    localparam int LANES_MAX = 4;

    function automatic bit lanes_legal(input int n);
        return (n == 2) || (n == 4);
    endfunction

endpackage

// File: rtl/lane_group_fifo.sv
// Two-entry synchronous FIFO holding whole lane groups; full/empty come from
// a registered occupancy count so the producer never sees a same-cycle bypass.
module lane_group_fifo #(
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data = mem[rd_ptr_reg];
    assign full      = (count_reg == 2'd2);
    assign empty     = (count_reg == 2'd0);

endmodule

// File: rtl/byte_unstriping.sv
// Re-serializes lane groups into one byte per clock (lane 0 first) and checks
// STP/SDP..END/EDB framing. Optional macro BYTE_UNSTRIPING_SKP_DROP_EN squashes SKP bytes.
module byte_unstriping
    import byte_strip_pkg::*;
#(
    parameter int LANES = 4,
    parameter int BITS  = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [BITS-1:0]  LANE0,
    input  logic [BITS-1:0]  LANE1,
    input  logic [BITS-1:0]  LANE2,
    input  logic [BITS-1:0]  LANE3,
    input  logic [LANES-1:0] LANE_K,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [BITS-1:0]  D,
    output logic             DK,
    output logic             D_VALID,
    output logic             IN_PKT,
    output logic             FRAME_ERR
);

    localparam int IDX_W   = (LANES > 2) ? 2 : 1;
    localparam int ENTRY_W = LANES * (BITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    logic [BITS-1:0]    lane_in [LANES_MAX];
    logic [BITS-1:0]    head_byte [LANES];
    logic [LANES-1:0]   head_k;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;

    logic [IDX_W-1:0]   idx_reg;
    logic [BITS-1:0]    d_reg;
    logic               dk_reg;
    logic               d_valid_reg;
    logic               frame_err_reg;
    logic               frame_err_next;
    frame_state_e       state_reg;
    frame_state_e       state_next;

    logic [BITS-1:0]    cur_byte;
    logic               cur_k;
    logic               emit;

    assign lane_in[0] = LANE0;
    assign lane_in[1] = LANE1;
    assign lane_in[2] = LANE2;
    assign lane_in[3] = LANE3;

    // Entry layout: lane bytes packed from bit 0 upward, K flags on top.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign push_data[gi*BITS +: BITS] = lane_in[gi];
            assign head_byte[gi]              = head_data[gi*BITS +: BITS];
        end
    endgenerate
    assign push_data[ENTRY_W-1 -: LANES] = LANE_K;
    assign head_k                        = head_data[ENTRY_W-1 -: LANES];

    assign IN_READY = !RESET && !fifo_full;
    assign push     = IN_VALID && IN_READY;
    assign pop      = !fifo_empty && (idx_reg == LAST_IDX);

    lane_group_fifo #(
        .WIDTH(ENTRY_W)
    ) u_fifo (
        .clk      (CLK),
        .srst     (RESET),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .head_data(head_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign cur_byte = head_byte[idx_reg];
    assign cur_k    = head_k[idx_reg];

`ifdef BYTE_UNSTRIPING_SKP_DROP_EN
    // A dropped SKP still burns its slot; it is invisible to framing.
    assign emit = !fifo_empty && !(cur_k && (cur_byte[7:0] == K_SKP));
`else
    assign emit = !fifo_empty;
`endif

    always_comb begin
        state_next     = state_reg;
        frame_err_next = 1'b0;
        if (emit) begin
            if (!cur_k) begin
                frame_err_next = (state_reg == FRAME_IDLE);
            end else begin
                case (cur_byte[7:0])
                    K_STP, K_SDP: begin
                        frame_err_next = (state_reg == FRAME_PKT);
                        state_next     = FRAME_PKT;
                    end
                    K_END, K_EDB: begin
                        frame_err_next = (state_reg == FRAME_IDLE);
                        state_next     = FRAME_IDLE;
                    end
                    K_IDL: begin
                        frame_err_next = (state_reg == FRAME_PKT);
                        state_next     = FRAME_IDLE;
                    end
                    K_COM, K_SKP: begin
                        state_next = state_reg;
                    end
                    default: begin
                        frame_err_next = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            idx_reg       <= '0;
            d_reg         <= '0;
            dk_reg        <= 1'b0;
            d_valid_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            state_reg     <= FRAME_IDLE;
        end else begin
            d_valid_reg   <= emit;
            frame_err_reg <= frame_err_next;
            state_reg     <= state_next;
            if (emit) begin
                d_reg  <= cur_byte;
                dk_reg <= cur_k;
            end
            if (!fifo_empty) begin
                idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
            end
        end
    end

    assign D         = d_reg;
    assign DK        = dk_reg;
    assign D_VALID   = d_valid_reg;
    assign FRAME_ERR = frame_err_reg;
    assign IN_PKT    = (state_reg == FRAME_PKT);

endmodule

// File: tb/tb_byte_unstriping.sv
// Directed bench for byte_unstriping (LANES=4, BITS=8); inputs change on the
// falling edge and outputs are sampled on the falling edge.
module tb_byte_unstriping;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] LANE0, LANE1, LANE2, LANE3;
    logic [3:0] LANE_K;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] D;
    logic       DK;
    logic       D_VALID;
    logic       IN_PKT;
    logic       FRAME_ERR;

    int pass_cnt  = 0;
    int total_cnt = 0;

    byte_unstriping #(.LANES(4), .BITS(8)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .LANE0    (LANE0),
        .LANE1    (LANE1),
        .LANE2    (LANE2),
        .LANE3    (LANE3),
        .LANE_K   (LANE_K),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .D        (D),
        .DK       (DK),
        .D_VALID  (D_VALID),
        .IN_PKT   (IN_PKT),
        .FRAME_ERR(FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    // Called at a falling edge; the group is pushed on the next rising edge
    // and the call returns at the following falling edge.
    task automatic drive_group(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3,
                               input logic [3:0] k);
        LANE0 = b0; LANE1 = b1; LANE2 = b2; LANE3 = b3; LANE_K = k;
        IN_VALID = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        IN_VALID = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; IN_VALID = 1'b0;
        LANE0 = '0; LANE1 = '0; LANE2 = '0; LANE3 = '0; LANE_K = '0;
        repeat (3) @(negedge CLK);
        total_cnt++; if (D_VALID !== 1'b0) $display("FAIL reset_d_valid got %b expected 0", D_VALID); else pass_cnt++;
        total_cnt++; if (D !== 8'h00) $display("FAIL reset_d got %h expected 00", D); else pass_cnt++;
        total_cnt++; if (DK !== 1'b0) $display("FAIL reset_dk got %b expected 0", DK); else pass_cnt++;
        total_cnt++; if (IN_PKT !== 1'b0) $display("FAIL reset_in_pkt got %b expected 0", IN_PKT); else pass_cnt++;
        total_cnt++; if (FRAME_ERR !== 1'b0) $display("FAIL reset_frame_err got %b expected 0", FRAME_ERR); else pass_cnt++;
        total_cnt++; if (IN_READY !== 1'b0) $display("FAIL reset_in_ready got %b expected 0", IN_READY); else pass_cnt++;
        RESET = 1'b0;
        #1;
        total_cnt++; if (IN_READY !== 1'b1) $display("FAIL post_reset_in_ready got %b expected 1", IN_READY); else pass_cnt++;
        @(negedge CLK);
    endtask

    task automatic test_basic_packet();
        logic [7:0] exp_d [4] = '{8'hFB, 8'h33, 8'hFF, 8'hFD};
        logic       exp_k [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       exp_p [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        drive_group(8'hFB, 8'h33, 8'hFF, 8'hFD, 4'b1001);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            total_cnt++; if (D_VALID !== 1'b1) $display("FAIL basic_valid[%0d] got %b expected 1", i, D_VALID); else pass_cnt++;
            total_cnt++; if (D !== exp_d[i]) $display("FAIL basic_d[%0d] got %h expected %h", i, D, exp_d[i]); else pass_cnt++;
            total_cnt++; if (DK !== exp_k[i]) $display("FAIL basic_dk[%0d] got %b expected %b", i, DK, exp_k[i]); else pass_cnt++;
            total_cnt++; if (IN_PKT !== exp_p[i]) $display("FAIL basic_in_pkt[%0d] got %b expected %b", i, IN_PKT, exp_p[i]); else pass_cnt++;
            total_cnt++; if (FRAME_ERR !== 1'b0) $display("FAIL basic_err[%0d] got %b expected 0", i, FRAME_ERR); else pass_cnt++;
        end
        @(negedge CLK);
        total_cnt++; if (D_VALID !== 1'b0) $display("FAIL basic_idle_valid got %b expected 0", D_VALID); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] grp [3][4] = '{'{8'hFB, 8'h10, 8'h11, 8'h12},
                                   '{8'h20, 8'h21, 8'h22, 8'h23},
                                   '{8'h30, 8'h31, 8'h32, 8'hFD}};
        logic [3:0] grp_k [3]  = '{4'b0001, 4'b0000, 4'b1000};
        logic       exp_rdy [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        int np = 0;
        int j;
        logic hs;
        for (int k = 0; k < 15; k++) begin
            // Falling edge k observes the state left by rising edge k-1.
            j = k - 2;
            if (k < 6) begin
                total_cnt++; if (IN_READY !== exp_rdy[k]) $display("FAIL b2b_in_ready[%0d] got %b expected %b", k, IN_READY, exp_rdy[k]); else pass_cnt++;
            end
            if (j >= 0 && j < 12) begin
                total_cnt++; if (D_VALID !== 1'b1) $display("FAIL b2b_valid[%0d] got %b expected 1", j, D_VALID); else pass_cnt++;
                total_cnt++; if (D !== grp[j/4][j%4]) $display("FAIL b2b_d[%0d] got %h expected %h", j, D, grp[j/4][j%4]); else pass_cnt++;
                total_cnt++; if (DK !== grp_k[j/4][j%4]) $display("FAIL b2b_dk[%0d] got %b expected %b", j, DK, grp_k[j/4][j%4]); else pass_cnt++;
                total_cnt++; if (FRAME_ERR !== 1'b0) $display("FAIL b2b_err[%0d] got %b expected 0", j, FRAME_ERR); else pass_cnt++;
            end else if (j == 12) begin
                total_cnt++; if (D_VALID !== 1'b0) $display("FAIL b2b_tail_valid got %b expected 0", D_VALID); else pass_cnt++;
            end
            if (np < 3) begin
                LANE0 = grp[np][0]; LANE1 = grp[np][1]; LANE2 = grp[np][2]; LANE3 = grp[np][3];
                LANE_K = grp_k[np];
                IN_VALID = 1'b1;
            end else begin
                IN_VALID = 1'b0;
            end
            hs = IN_VALID && IN_READY;
            @(posedge CLK);
            if (hs) np++;
            @(negedge CLK);
        end
        IN_VALID = 1'b0;
        total_cnt++; if (np != 3) $display("FAIL b2b_push_count got %0d expected 3", np); else pass_cnt++;
    endtask

    task automatic test_idle_data_err();
        logic [7:0] exp_d [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        drive_group(8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            total_cnt++; if (D !== exp_d[i]) $display("FAIL idle_data_d[%0d] got %h expected %h", i, D, exp_d[i]); else pass_cnt++;
            total_cnt++; if (FRAME_ERR !== 1'b1) $display("FAIL idle_data_err[%0d] got %b expected 1", i, FRAME_ERR); else pass_cnt++;
            total_cnt++; if (IN_PKT !== 1'b0) $display("FAIL idle_data_in_pkt[%0d] got %b expected 0", i, IN_PKT); else pass_cnt++;
        end
        @(negedge CLK);
        total_cnt++; if (FRAME_ERR !== 1'b0) $display("FAIL idle_data_err_clear got %b expected 0", FRAME_ERR); else pass_cnt++;
    endtask

    task automatic test_double_stp();
        logic [7:0] exp_d   [4] = '{8'hFB, 8'h11, 8'hFB, 8'h22};
        logic       exp_err [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        drive_group(8'hFB, 8'h11, 8'hFB, 8'h22, 4'b0101);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            total_cnt++; if (D !== exp_d[i]) $display("FAIL dstp_d[%0d] got %h expected %h", i, D, exp_d[i]); else pass_cnt++;
            total_cnt++; if (FRAME_ERR !== exp_err[i]) $display("FAIL dstp_err[%0d] got %b expected %b", i, FRAME_ERR, exp_err[i]); else pass_cnt++;
            total_cnt++; if (IN_PKT !== 1'b1) $display("FAIL dstp_in_pkt[%0d] got %b expected 1", i, IN_PKT); else pass_cnt++;
        end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid_group();
        logic [7:0] exp_d [2] = '{8'h40, 8'h41};
        drive_group(8'h40, 8'h41, 8'h42, 8'h43, 4'b0000);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            total_cnt++; if (D !== exp_d[i] || D_VALID !== 1'b1) $display("FAIL mid_rst_pre_d[%0d] got %h/%b expected %h/1", i, D, D_VALID, exp_d[i]); else pass_cnt++;
        end
        RESET = 1'b1;
        #1;
        total_cnt++; if (IN_READY !== 1'b0) $display("FAIL mid_rst_in_ready got %b expected 0", IN_READY); else pass_cnt++;
        @(negedge CLK);
        total_cnt++; if (D_VALID !== 1'b0) $display("FAIL mid_rst_valid got %b expected 0", D_VALID); else pass_cnt++;
        total_cnt++; if (IN_PKT !== 1'b0) $display("FAIL mid_rst_in_pkt got %b expected 0", IN_PKT); else pass_cnt++;
        total_cnt++; if (FRAME_ERR !== 1'b0) $display("FAIL mid_rst_err got %b expected 0", FRAME_ERR); else pass_cnt++;
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            total_cnt++; if (D_VALID !== 1'b0) $display("FAIL mid_rst_after_valid[%0d] got %b expected 0", i, D_VALID); else pass_cnt++;
        end
    endtask

    task automatic test_unknown_k();
        logic       exp_err [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic       exp_p   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        // STP, IDL inside a packet, unknown K 3C, END while idle.
        drive_group(8'hFB, 8'h7C, 8'h3C, 8'hFD, 4'b1111);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            total_cnt++; if (FRAME_ERR !== exp_err[i]) $display("FAIL unk_err[%0d] got %b expected %b", i, FRAME_ERR, exp_err[i]); else pass_cnt++;
            total_cnt++; if (IN_PKT !== exp_p[i]) $display("FAIL unk_in_pkt[%0d] got %b expected %b", i, IN_PKT, exp_p[i]); else pass_cnt++;
        end
        @(negedge CLK);
    endtask

    task automatic test_skp();
`ifdef BYTE_UNSTRIPING_SKP_DROP_EN
        logic       exp_v [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] exp_d [4] = '{8'hBC, 8'hBC, 8'hBC, 8'hBC};
`else
        logic       exp_v [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
        logic [7:0] exp_d [4] = '{8'hBC, 8'h1C, 8'h1C, 8'h1C};
`endif
        drive_group(8'hBC, 8'h1C, 8'h1C, 8'h1C, 4'b1111);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            total_cnt++; if (D_VALID !== exp_v[i]) $display("FAIL skp_valid[%0d] got %b expected %b", i, D_VALID, exp_v[i]); else pass_cnt++;
            total_cnt++; if (D !== exp_d[i]) $display("FAIL skp_d[%0d] got %h expected %h", i, D, exp_d[i]); else pass_cnt++;
            total_cnt++; if (FRAME_ERR !== 1'b0 || IN_PKT !== 1'b0) $display("FAIL skp_frame[%0d] got err=%b pkt=%b expected 0/0", i, FRAME_ERR, IN_PKT); else pass_cnt++;
        end
        @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_basic_packet();
        test_back_to_back();
        test_idle_data_err();
        test_double_stp();
        test_reset_mid_group();
        test_unknown_k();
        test_skp();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
